// File: rtl/bc_bo_pkg.sv
// Shared definitions between the step-sequencing control block and the operative datapath.
// Holds the operand-select and ALU op encodings and the packed control word.
package bc_bo_pkg;

  // M0: ALU operand A select
  localparam logic [1:0] A_DIN = 2'd0;
  localparam logic [1:0] A_X   = 2'd1;
  localparam logic [1:0] A_S   = 2'd2;
  localparam logic [1:0] A_H   = 2'd3;

  // M1: ALU operand B select
  localparam logic [1:0] B_X    = 2'd0;
  localparam logic [1:0] B_S    = 2'd1;
  localparam logic [1:0] B_H    = 2'd2;
  localparam logic [1:0] B_ZERO = 2'd3;

  // M2: ALU operation
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_PASS = 2'd3;

  typedef struct packed {
    logic       lx;
    logic       ls;
    logic       lh;
    logic       h;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
  } ctrl_word_t;

  localparam ctrl_word_t IDLE_WORD = '0;

endpackage

// File: rtl/bo_alu.sv
// Combinational ALU for the operative datapath: add, sub, low-half mul, pass A.
// ovf flags results that do not fit WIDTH bits unsigned.
module bo_alu
  import bc_bo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             ovf
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    r   = a;
    ovf = 1'b0;
    unique case (op)
      OP_ADD: begin
        r   = sum[WIDTH-1:0];
        ovf = sum[WIDTH];
      end
      OP_SUB: begin
        r   = diff[WIDTH-1:0];
        ovf = diff[WIDTH];  // borrow out means a < b
      end
      OP_MUL: begin
        r   = prod[WIDTH-1:0];
        ovf = |prod[2*WIDTH-1:WIDTH];
      end
      OP_PASS: begin
        r   = a;
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bo_datapath.sv
// Operative datapath: applies one control word per cycle to X, S, H and commits S
// on a valid/ready result port when an idle word follows at least one S load.
module bo_datapath
  import bc_bo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             LX,
  input  logic             LS,
  input  logic             LH,
  input  logic             H,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  output logic [WIDTH-1:0] x_q,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] h_q,
  output logic [WIDTH-1:0] result,
  output logic             result_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  ctrl_word_t       cw;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_r;
  logic             alu_ovf;
  logic             pending_q;
  logic             ovf_acc_q;
  logic             commit;
  logic             alu_load;
  logic             slot_free;

  assign cw = '{lx: LX, ls: LS, lh: LH, h: H, m0: M0, m1: M1, m2: M2};

  always_comb begin
    op_a = din;
    unique case (M0)
      A_DIN: op_a = din;
      A_X:   op_a = x_q;
      A_S:   op_a = s_q;
      A_H:   op_a = h_q;
    endcase
  end

  always_comb begin
    op_b = '0;
    unique case (M1)
      B_X:    op_b = x_q;
      B_S:    op_b = s_q;
      B_H:    op_b = h_q;
      B_ZERO: op_b = '0;
    endcase
  end

  bo_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a  (op_a),
    .b  (op_b),
    .op (M2),
    .r  (alu_r),
    .ovf(alu_ovf)
  );

  assign commit    = (cw == IDLE_WORD) && pending_q;
  assign alu_load  = LS || (LH && H);
  // The slot can take a new result if empty or if its current one leaves this cycle.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      s_q        <= '0;
      h_q        <= '0;
      result     <= '0;
      result_ovf <= 1'b0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      pending_q  <= 1'b0;
      ovf_acc_q  <= 1'b0;
    end else begin
      if (LX) x_q <= din;
      if (LS) s_q <= alu_r;
      if (LH) h_q <= H ? alu_r : din;

      if (commit) begin
        pending_q <= 1'b0;
        ovf_acc_q <= 1'b0;
      end else begin
        if (LS) pending_q <= 1'b1;
        if (alu_load && alu_ovf) ovf_acc_q <= 1'b1;
      end

      if (commit && slot_free) begin
        result     <= s_q;
        result_ovf <= ovf_acc_q;
        out_valid  <= 1'b1;
      end else begin
        if (commit) overrun <= 1'b1;
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bo_datapath.sv
// Self-checking bench for bo_datapath: directed scenarios plus randomized control words
// checked against a behavioural model of the datapath rules.
module tb_bo_datapath;
  import bc_bo_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         LX, LS, LH, H;
  logic [1:0]   M0, M1, M2;
  logic [W-1:0] x_q, s_q, h_q, result;
  logic         result_ovf, out_valid, out_ready, overrun;

  int checks = 0;
  int passes = 0;

  // Behavioural model state
  int mx, ms, mh, mres;
  bit mpend, macc, movf, mvalid, mover;

  always #5 clk = ~clk;

  bo_datapath #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .LX        (LX),
    .LS        (LS),
    .LH        (LH),
    .H         (H),
    .M0        (M0),
    .M1        (M1),
    .M2        (M2),
    .x_q       (x_q),
    .s_q       (s_q),
    .h_q       (h_q),
    .result    (result),
    .result_ovf(result_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  // Apply one control word for one clock, advance the model, settle 1 time unit past the edge.
  task automatic drive(input bit rst, input bit lx, input bit ls, input bit lh, input bit hs,
                       input int m0, input int m1, input int m2, input int d, input bit rdy);
    int a, b, full, r;
    bit ov, idle, commit;
    reset = rst; LX = lx; LS = ls; LH = lh; H = hs;
    M0 = m0[1:0]; M1 = m1[1:0]; M2 = m2[1:0]; din = d[7:0]; out_ready = rdy;
    @(posedge clk);
    if (rst) begin
      mx = 0; ms = 0; mh = 0; mres = 0;
      mpend = 0; macc = 0; movf = 0; mvalid = 0; mover = 0;
    end else begin
      a = (m0 == 0) ? d : (m0 == 1) ? mx : (m0 == 2) ? ms : mh;
      b = (m1 == 0) ? mx : (m1 == 1) ? ms : (m1 == 2) ? mh : 0;
      case (m2)
        0:       full = a + b;
        1:       full = a - b;
        2:       full = a * b;
        default: full = a;
      endcase
      ov     = (m2 != 3) && (full < 0 || full > 255);
      r      = full & 255;
      idle   = !(lx || ls || lh || hs) && m0 == 0 && m1 == 0 && m2 == 0;
      commit = idle && mpend;
      if (commit) begin
        if (!mvalid || rdy) begin
          mres = ms; movf = macc; mvalid = 1;
        end else begin
          mover = 1;
        end
        mpend = 0; macc = 0;
      end else begin
        if (mvalid && rdy) mvalid = 0;
        if (ls) mpend = 1;
        if ((ls || (lh && hs)) && ov) macc = 1;
      end
      if (lx) mx = d;
      if (ls) ms = r;
      if (lh) mh = hs ? r : d;
    end
    #1;
  endtask

  task automatic idle_word(input bit rdy);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++; if (x_q !== 8'd0 || s_q !== 8'd0 || h_q !== 8'd0)
      $display("FAIL reset_regs got x=%0d s=%0d h=%0d exp 0 0 0", x_q, s_q, h_q); else passes++;
    checks++; if (result !== 8'd0 || result_ovf !== 1'b0)
      $display("FAIL reset_result got %0d/%0b exp 0/0", result, result_ovf); else passes++;
    checks++; if (out_valid !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_flags got v=%0b o=%0b exp 0 0", out_valid, overrun); else passes++;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 9, 1);
    checks++; if (x_q !== 8'd0) $display("FAIL reset_ignores_lx got %0d exp 0", x_q); else passes++;
  endtask

  task automatic test_square();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 5, 1);
    checks++; if (x_q !== 8'd5) $display("FAIL sq_load_x got %0d exp 5", x_q); else passes++;
    drive(0, 0, 1, 0, 0, 1, 0, 2, 0, 1);
    checks++; if (s_q !== 8'd25) $display("FAIL sq_load_s got %0d exp 25", s_q); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL sq_early_valid got %0b exp 0", out_valid);
    else passes++;
    idle_word(1);
    checks++; if (out_valid !== 1'b1 || result !== 8'd25 || result_ovf !== 1'b0)
      $display("FAIL sq_commit got v=%0b r=%0d ovf=%0b exp 1 25 0", out_valid, result, result_ovf);
    else passes++;
    idle_word(1);
    checks++; if (out_valid !== 1'b0) $display("FAIL sq_drain got %0b exp 0", out_valid);
    else passes++;
  endtask

  task automatic test_overflow();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 20, 1);
    drive(0, 0, 1, 0, 0, 1, 0, 2, 0, 1);
    idle_word(1);
    checks++; if (result !== 8'd144 || result_ovf !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL ovf_mul got r=%0d ovf=%0b v=%0b exp 144 1 1", result, result_ovf, out_valid);
    else passes++;
    idle_word(1);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 3, 1);
    drive(0, 0, 1, 0, 0, 1, 0, 3, 0, 1);
    idle_word(1);
    checks++; if (result !== 8'd3 || result_ovf !== 1'b0)
      $display("FAIL ovf_cleared got r=%0d ovf=%0b exp 3 0", result, result_ovf); else passes++;
    idle_word(1);
    // H loaded from the ALU also feeds the overflow flag: 10 - 20 borrows
    drive(0, 1, 0, 0, 0, 0, 0, 0, 20, 1);
    drive(0, 0, 0, 1, 1, 0, 0, 1, 10, 1);
    checks++; if (h_q !== 8'd246) $display("FAIL h_alu got %0d exp 246", h_q); else passes++;
    drive(0, 0, 1, 0, 0, 3, 3, 3, 0, 1);
    idle_word(1);
    checks++; if (result !== 8'd246 || result_ovf !== 1'b1)
      $display("FAIL h_ovf got r=%0d ovf=%0b exp 246 1", result, result_ovf); else passes++;
    idle_word(1);
  endtask

  task automatic test_overrun();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 3, 0);
    drive(0, 0, 1, 0, 0, 1, 0, 3, 0, 0);
    idle_word(0);
    checks++; if (out_valid !== 1'b1 || result !== 8'd3)
      $display("FAIL ovr_first got v=%0b r=%0d exp 1 3", out_valid, result); else passes++;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 7, 0);
    drive(0, 0, 1, 0, 0, 1, 0, 3, 0, 0);
    idle_word(0);
    checks++; if (result !== 8'd3 || out_valid !== 1'b1 || overrun !== 1'b1 || s_q !== 8'd7)
      $display("FAIL ovr_drop got r=%0d v=%0b o=%0b s=%0d exp 3 1 1 7",
               result, out_valid, overrun, s_q); else passes++;
    idle_word(1);
    checks++; if (out_valid !== 1'b0 || overrun !== 1'b1)
      $display("FAIL ovr_release got v=%0b o=%0b exp 0 1", out_valid, overrun); else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 5, 0);
    drive(0, 0, 1, 0, 0, 1, 0, 3, 0, 0);
    idle_word(0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 11, 0);
    drive(0, 0, 1, 0, 0, 1, 0, 3, 0, 0);
    checks++; if (out_valid !== 1'b1 || result !== 8'd5)
      $display("FAIL b2b_held got v=%0b r=%0d exp 1 5", out_valid, result); else passes++;
    idle_word(1);
    checks++; if (result !== 8'd11 || out_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL b2b_commit got r=%0d v=%0b o=%0b exp 11 1 0", result, out_valid, overrun);
    else passes++;
    idle_word(1);
    checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %0b exp 0", out_valid);
    else passes++;
  endtask

  task automatic test_no_commit();
    do_reset();
    idle_word(1);
    checks++; if (out_valid !== 1'b0) $display("FAIL idle_no_ls got %0b exp 0", out_valid);
    else passes++;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 200, 1);
    drive(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    do_reset();
    idle_word(1);
    checks++; if (out_valid !== 1'b0 || s_q !== 8'd0)
      $display("FAIL rst_mid_seq got v=%0b s=%0d exp 0 0", out_valid, s_q); else passes++;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 1, 0, 0, 1, 0, 3, 0, 1);
    idle_word(1);
    checks++; if (result !== 8'd1 || result_ovf !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL rst_clears_ovf got r=%0d ovf=%0b v=%0b exp 1 0 1",
               result, result_ovf, out_valid); else passes++;
  endtask

  task automatic test_random();
    bit rst, lx, ls, lh, hs, rdy;
    int m0, m1, m2, d, roll;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      roll = $urandom_range(0, 99);
      rst = (roll < 2);
      rdy = ($urandom_range(0, 2) != 0);
      d   = $urandom_range(0, 255);
      if (roll >= 2 && roll < 30) begin
        lx = 0; ls = 0; lh = 0; hs = 0; m0 = 0; m1 = 0; m2 = 0;
      end else begin
        lx = $urandom_range(0, 1); ls = ($urandom_range(0, 2) == 0);
        lh = $urandom_range(0, 1); hs = $urandom_range(0, 1);
        m0 = $urandom_range(0, 3); m1 = $urandom_range(0, 3); m2 = $urandom_range(0, 3);
      end
      drive(rst, lx, ls, lh, hs, m0, m1, m2, d, rdy);
      checks++; if (x_q !== mx[7:0] || s_q !== ms[7:0] || h_q !== mh[7:0])
        $display("FAIL rnd_regs cyc %0d got %0d %0d %0d exp %0d %0d %0d",
                 i, x_q, s_q, h_q, mx, ms, mh); else passes++;
      checks++; if (out_valid !== mvalid || overrun !== mover)
        $display("FAIL rnd_flags cyc %0d got v=%0b o=%0b exp %0b %0b",
                 i, out_valid, overrun, mvalid, mover); else passes++;
      checks++; if (result !== mres[7:0] || result_ovf !== movf)
        $display("FAIL rnd_result cyc %0d got %0d/%0b exp %0d/%0b",
                 i, result, result_ovf, mres, movf); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_overflow();
    test_overrun();
    test_back_to_back();
    test_no_commit();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bo_datapath.md
# bo_datapath

Operative datapath driven by the step-sequencing control block. Each cycle it consumes one control word (LX, LS, LH, H, M0, M1, M2) and applies it to three working registers (X, S, H) through a shared ALU. When the sequence ends (idle word after at least one S load), it commits S as a result on a valid/ready output port. It is the direct downstream consumer of the control block's outputs and the producer of the system's results.

## Interface
- WIDTH, 8, data width of din, X, S, H and result
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- din  in  WIDTH  external operand
- LX  in  1  load X from din
- LS  in  1  load S from ALU result
- LH  in  1  load H (source chosen by H)
- H  in  1  H-source select: 1 = ALU result, 0 = din
- M0  in  2  ALU operand A select: 0 din, 1 X, 2 S, 3 H
- M1  in  2  ALU operand B select: 0 X, 1 S, 2 H, 3 zero
- M2  in  2  ALU op: 0 add, 1 sub (A−B), 2 mul (low WIDTH bits), 3 pass A
- x_q, s_q, h_q  out  WIDTH  current register contents (observation)
- result  out  WIDTH  committed S value
- result_ovf  out  1  an overflowing ALU load occurred in the committed sequence
- out_valid  out  1  result held and valid
- out_ready  in  1  consumer accepts result
- overrun  out  1  sticky; a commit was dropped

## Operation
- ALU is combinational: A = mux(M0), B = mux(M1), R = op(M2) truncated to WIDTH.
- Overflow event when the full-precision value does not fit WIDTH unsigned: add carry-out, sub borrow (A<B), mul high half nonzero. Pass never overflows.
- Per cycle, all register loads are independent and simultaneous:
  - LX: X<=din.
  - LS: S<=R.
  - LH: H<=(H ? R : din).
  - Operands use pre-edge register values.
- ovf_acc (internal) is set on an overflow event at any ALU load: LS=1, or LH=1 with H=1.
- pending (internal) is set by any LS load.
- Idle word: LX=LS=LH=H=0, M0=M1=M2=0.
- Commit condition: idle word sampled and pending=1.
  - On commit, pending and ovf_acc are cleared.
  - An idle word with pending=0 does nothing.
- Output slot behaviour on commit:
  - Slot empty (out_valid=0), or out_valid=1 with out_ready=1: result<=S, result_ovf<=ovf_acc, out_valid<=1.
  - Slot full and out_ready=0: commit is dropped, overrun<=1, result and result_ovf are unchanged. pending and ovf_acc are still cleared.
- Handshake: transfer on out_valid & out_ready. Without a commit in that cycle, out_valid<=0 next cycle.
- While out_valid=1 and out_ready=0, result and result_ovf are held stable.
- overrun clears only on reset.
- Reset (also mid-sequence):
  - X, S, H, result = 0.
  - out_valid, result_ovf, overrun, pending, ovf_acc = 0.
  - The control word present in the reset cycle is ignored.

## Timing
- Register loads are visible on x_q/s_q/h_q one cycle after the control word is sampled.
- Commit latency: out_valid rises the cycle after the idle word is sampled. result equals S as of that idle cycle.
- A five-word sequence followed by an idle word yields a result 6 cycles after the first word.
- Throughput: one commit per sequence. A back-to-back commit is accepted only if the prior result transfers in the commit cycle.
- No combinational path from out_ready to out_valid or result.

## Structure
- Shared package bc_bo_pkg:
  - M0/M1 select constants and M2 op constants (OP_ADD, OP_SUB, OP_MUL, OP_PASS).
  - Packed control-word typedef and the IDLE_WORD constant.
  - Also imported by the control block.
- One sub-module, bo_alu:
  - Combinational; operands, op → WIDTH-bit result plus ovf.
  - Registers, commit logic and output slot remain in bo_datapath.

## Test plan
- Reset → all outputs 0, out_valid=0, overrun=0. Hold reset while LX=1, din=9 → X stays 0.
- din=5, LX=1; then M0=1, M1=0, M2=2, LS=1; then idle → S=25, next cycle out_valid=1, result=25, result_ovf=0.
- X=20, then X*X into S, then idle → result=144 (400 mod 256), result_ovf=1. A following sequence without overflow commits result_ovf=0.
- out_ready=0 with two commits (S=3, then S=7) → result stays 3, overrun=1. Raise out_ready → out_valid drops next cycle.
- out_valid=1 with out_ready=1 in the same cycle as a commit of S=11 → result=11, out_valid stays 1, overrun=0.
- Idle word with no prior LS → no commit. Reset asserted mid-sequence after an LS load, then idle → no commit, pending cleared.
